if_id_stage: RTL
================

Name: if_id_stage

Overview:
Fetch-side front end of the 5-stage MIPS pipeline. It holds the program counter, drives the instruction-memory address, and captures the fetched instruction into the IF/ID pipeline register. It consumes the stall controls from the load-use hazard detector (pc_store, if_id_write) and the branch redirect from the branch-resolution stage. It feeds if_id_rs / if_id_rt back to the hazard detector and passes the instruction to decode.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC and address width; must be 32 for this core

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
pc_store  in  1  1 = PC may advance; 0 = hold PC (load-use stall)
if_id_write  in  1  1 = IF/ID register may load; 0 = hold IF/ID
branch_taken  in  1  redirect request from branch resolution, valid this cycle
branch_target  in  32  redirect PC, word-aligned
instr_in  in  32  instruction memory read data for address pc_out (combinational memory)
pc_out  out  32  current fetch PC to instruction memory
if_id_pc4  out  32  registered PC+4 of instruction in IF/ID
if_id_instr  out  32  registered instruction in IF/ID
if_id_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble
if_id_rs  out  5  if_id_instr[25:21], combinational from register
if_id_rt  out  5  if_id_instr[20:16], combinational from register

Behaviour:
- Reset (rst high, asynchronous, any time, including mid-stall): pc_out=RESET_PC, if_id_instr=32'h0 (NOP), if_id_pc4=0, if_id_valid=0. Counters (optional feature) clear to 0.
- First rising edge after reset deassertion: normal fetch of RESET_PC. No extra boot cycle.
- PC update per edge, priority order:
  1. branch_taken=1: PC <= branch_target (pc_store is ignored).
  2. pc_store=1: PC <= PC+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  3. otherwise: PC holds.
- IF/ID update per edge, priority order:
  1. branch_taken=1: flush. if_id_instr <= 0, if_id_pc4 <= 0, if_id_valid <= 0. Flush overrides if_id_write=0.
  2. if_id_write=1: if_id_instr <= instr_in, if_id_pc4 <= PC+4, if_id_valid <= 1.
  3. otherwise: all IF/ID fields hold.
- Latency: the instruction at PC appears on if_id_instr one edge after PC is presented.
- pc_store=1 with if_id_write=0 (or the reverse) is illegal from the hazard detector. The behaviour still follows the rules above independently; the bench flags it as an assertion.
- Stalled cycles re-present the same pc_out. instr_in must be stable across the stall.
- branch_target bits [1:0] are not checked; they are passed through as given.
- if_id_rs / if_id_rt reflect the held instruction during a stall, so hazard detection re-evaluates against unchanged operands.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds outputs stall_cycles[31:0] and flush_cycles[31:0].
  - stall_cycles increments on each edge with pc_store=0 and branch_taken=0.
  - flush_cycles increments on each edge with branch_taken=1.
  - Both wrap at 2^32 and clear on rst.
- Undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR = 32'h0
  - PC_INC = 4
  - RS_MSB/LSB = 25/21
  - RT_MSB/LSB = 20/16
  - RESET_PC default
- One sub-module: pc_reg. It holds the PC with async reset, branch/advance/hold priority, and the +4 incrementer, and exports pc and pc_plus4. The IF/ID register stays in the top.

Test Plan:
- Reset then 3 free-running edges with instr_in = 32'h8C220004, 32'h00430820, 32'hAC010008. pc_out goes 0→4→8→C. if_id_instr tracks each word one edge later. if_id_pc4 = 4, 8, C. if_id_valid rises after the first edge.
- Load-use stall: at PC=8 hold pc_store=0 and if_id_write=0 for 1 edge. pc_out stays 8. if_id_instr stays 32'h00430820. if_id_rs=2 and if_id_rt=3 are unchanged. Advance resumes on the next edge.
- Branch taken with branch_target=32'h40 while stalled (pc_store=0). Next edge: pc_out=40, if_id_instr=0, if_id_valid=0. The following edge loads the instruction at 40.
- Wrap: force PC to 32'hFFFF_FFFC via branch, then advance. pc_out=0 and if_id_pc4=0.
- Async reset asserted mid-cycle during a stall with PC=C. pc_out goes to RESET_PC and if_id_valid goes to 0 immediately, without waiting for a clock edge.
- FETCH_PERF_CNT_EN defined: 2 stall edges plus 1 branch edge. Expect stall_cycles=2 and flush_cycles=1. A simultaneous stall and branch counts only as a flush.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Package  : mips_pkg
// Brief    : Shared constants for the MIPS fetch front end (NOP encoding, PC
//            increment, register-field positions, reset PC).
// Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

    localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;
    localparam int unsigned c_PC_INC    = 4;
    localparam int unsigned c_RS_MSB    = 25;
    localparam int unsigned c_RS_LSB    = 21;
    localparam int unsigned c_RT_MSB    = 20;
    localparam int unsigned c_RT_LSB    = 16;
    localparam logic [31:0] c_RESET_PC  = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/pc_reg.sv
`default_nettype none
// ============================================================================
// Module   : pc_reg
// Brief    : Program counter with async reset, branch > advance > hold
//            priority, and the +4 incrementer shared with the IF/ID register.
// Revision : 1.0 - initial release
// ============================================================================
module pc_reg
    import mips_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_store,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_plus4;

    // Truncation to ADDR_W gives the required modulo-2^32 wrap.
    assign w_pc_plus4 = r_pc + ADDR_W'(c_PC_INC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (branch_taken) begin
            r_pc <= branch_target;
        end else if (pc_store) begin
            r_pc <= w_pc_plus4;
        end
    end

    assign pc       = r_pc;
    assign pc_plus4 = w_pc_plus4;

endmodule
`default_nettype wire

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Brief    : MIPS fetch stage: PC, instruction-memory address and IF/ID
//            register. Define FETCH_PERF_CNT_EN to add stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = c_RESET_PC,
    parameter int unsigned ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pc_store,
    input  logic              if_id_write,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic [31:0]       instr_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic [31:0]       if_id_instr,
    output logic              if_id_valid,
    output logic [4:0]        if_id_rs,
    output logic [4:0]        if_id_rt
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       flush_cycles
`endif
);

    logic [ADDR_W-1:0] w_pc;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] r_if_id_pc4;
    logic [31:0]       r_if_id_instr;
    logic              r_if_id_valid;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (ADDR_W'(RESET_PC))
    ) u_pc_reg (
        .clk           (clk),
        .rst           (rst),
        .pc_store      (pc_store),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc            (w_pc),
        .pc_plus4      (w_pc_plus4)
    );

    // A redirect flushes the wrong-path instruction even while decode is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_if_id_instr <= c_NOP_INSTR;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (branch_taken) begin
            r_if_id_instr <= c_NOP_INSTR;
            r_if_id_pc4   <= '0;
            r_if_id_valid <= 1'b0;
        end else if (if_id_write) begin
            r_if_id_instr <= instr_in;
            r_if_id_pc4   <= w_pc_plus4;
            r_if_id_valid <= 1'b1;
        end
    end

    assign pc_out      = w_pc;
    assign if_id_pc4   = r_if_id_pc4;
    assign if_id_instr = r_if_id_instr;
    assign if_id_valid = r_if_id_valid;
    assign if_id_rs    = r_if_id_instr[c_RS_MSB:c_RS_LSB];
    assign if_id_rt    = r_if_id_instr[c_RT_MSB:c_RT_LSB];

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_cycles;

    // A stall coinciding with a redirect is counted only as a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
            r_flush_cycles <= '0;
        end else begin
            if (branch_taken) begin
                r_flush_cycles <= r_flush_cycles + 32'd1;
            end else if (!pc_store) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_cycles = r_flush_cycles;
`endif

endmodule
`default_nettype wire
